if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID
//  pipeline register. Drives pc_out into the shared 32-bit adder (in1=pc_out, in2=32'd4)
//  and consumes its sum on pc_plus4_in.
//  Selects the next PC from sequential, branch and jump sources.
//  Honours hazard-unit stalls and flushes on control-flow redirects.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  bubble instruction written into IF/ID on flush/reset (sll $0,$0,0)
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous, active-low reset
//  pc_out         out  32  current PC; to imem address and to adder in1
//  pc_plus4_in    in   32  adder sum (pc_out + 4), combinational from pc_out
//  imem_rdata     in   32  instruction at pc_out, combinational read
//  stall          in   1   hazard unit: hold PC and IF/ID this cycle
//  branch_taken   in   1   ID-stage branch resolved taken
//  branch_target  in   32  branch destination
//  jump_en        in   1   ID-stage j/jal/jr
//  jump_target    in   32  jump destination
//  ifid_instr     out  32  registered instruction for ID
//  ifid_pc_plus4  out  32  registered PC+4 for ID
//  ifid_valid     out  1   1 = ifid_instr is a real fetched instruction, 0 = bubble
//  misalign_err   out  1   sticky: a redirect target had bits[1:0] != 0
//  fetch_count    out  32  number of instructions loaded into IF/ID as valid
// BEHAVIOUR
//  Reset (rst_n=0, async, any time incl. mid-redirect/stall):
//   pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, misalign_err=0,
//   fetch_count=0.
//   First valid fetch lands in IF/ID on the first rising edge after rst_n deasserts.
//  Redirect = jump_en | branch_taken. Target priority: jump_en over branch_taken.
//  Per rising edge, highest priority first:
//   1 redirect: pc<=target with [1:0] forced to 2'b00; IF/ID<=bubble (NOP_INSTR, pc_plus4=0,
//     valid=0). Overrides stall.
//     If target[1:0]!=0, misalign_err<=1; stays 1 until reset.
//   2 stall (no redirect): pc, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count all hold.
//   3 normal: pc<=pc_plus4_in; ifid_instr<=imem_rdata; ifid_pc_plus4<=pc_plus4_in;
//     ifid_valid<=1; fetch_count<=fetch_count+1.
//  Latency: instruction at PC visible on ifid_* one cycle after pc_out shows that PC.
//  Arithmetic: all 32-bit unsigned; PC wrap 32'hFFFF_FFFC -> 32'h0 via adder, accepted
//   silently. fetch_count wraps 32'hFFFF_FFFF -> 0.
//  pc_plus4_in is used as-is; the block does not add internally.
//  Redirect and stall asserted together: the redirect is taken, and the stall is dropped
//   for that cycle.
//  Only fetch_count, misalign_err and the registers above are state; no FSM beyond this.
// TESTING
//  T1 reset: rst_n=0 mid-run -> pc_out=0, ifid_valid=0, ifid_instr=0 immediately (no clk edge).
//  T2 sequential: release reset, imem returns 32'h2008_0005 at 0 -> next edge pc_out=4,
//   ifid_instr=32'h2008_0005, ifid_pc_plus4=4, ifid_valid=1, fetch_count=1.
//  T3 stall: pc=8, stall=1 for 3 cycles -> pc_out=8 and ifid_* unchanged, fetch_count unchanged.
//  T4 branch+stall same cycle: branch_taken=1, branch_target=32'h40, stall=1 -> pc_out=32'h40,
//   ifid_valid=0, ifid_instr=NOP_INSTR.
//  T5 jump vs branch: jump_en=1 (jump_target=32'h100), branch_taken=1 (branch_target=32'h80)
//   -> pc_out=32'h100.
//  T6 misaligned/wrap: jump_target=32'h103 -> pc_out=32'h100, misalign_err=1 (sticky).
//   pc=32'hFFFF_FFFC, no redirect -> pc_out=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC and the IF/ID pipeline register. Next PC comes from the shared
// external adder (pc_plus4_in), or from a jump/branch redirect. Hazard stalls
// freeze the stage. A redirect squashes the IF/ID contents to a bubble.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_r;
    logic [31:0] ifid_instr_r;
    logic [31:0] ifid_pc_plus4_r;
    logic        ifid_valid_r;
    logic        misalign_err_r;
    logic [31:0] fetch_count_r;

    logic [31:0] pc_nxt_s;
    logic [31:0] ifid_instr_nxt_s;
    logic [31:0] ifid_pc_plus4_nxt_s;
    logic        ifid_valid_nxt_s;
    logic        misalign_err_nxt_s;
    logic [31:0] fetch_count_nxt_s;

    logic        redirect_s;
    logic [31:0] target_s;

    // Redirect detection; a jump wins over a branch when both fire together.
    always_comb begin
        redirect_s = jump_en | branch_taken;
        if (jump_en) begin
            target_s = jump_target;
        end else begin
            target_s = branch_target;
        end
    end

    // Next-state selection: redirect beats stall, stall beats sequential fetch.
    always_comb begin
        pc_nxt_s            = pc_r;
        ifid_instr_nxt_s    = ifid_instr_r;
        ifid_pc_plus4_nxt_s = ifid_pc_plus4_r;
        ifid_valid_nxt_s    = ifid_valid_r;
        misalign_err_nxt_s  = misalign_err_r;
        fetch_count_nxt_s   = fetch_count_r;
        if (redirect_s) begin
            // Low bits are dropped so the PC stays word aligned; the flag
            // records that software produced a bad target.
            pc_nxt_s            = {target_s[31:2], 2'b00};
            ifid_instr_nxt_s    = NOP_INSTR;
            ifid_pc_plus4_nxt_s = 32'h0000_0000;
            ifid_valid_nxt_s    = 1'b0;
            if (target_s[1:0] != 2'b00) begin
                misalign_err_nxt_s = 1'b1;
            end else begin
                misalign_err_nxt_s = misalign_err_r;
            end
        end else if (stall) begin
            pc_nxt_s            = pc_r;
            ifid_instr_nxt_s    = ifid_instr_r;
            ifid_pc_plus4_nxt_s = ifid_pc_plus4_r;
            ifid_valid_nxt_s    = ifid_valid_r;
        end else begin
            // The external adder supplies pc+4; wrap past the top of the
            // address space is accepted as-is.
            pc_nxt_s            = pc_plus4_in;
            ifid_instr_nxt_s    = imem_rdata;
            ifid_pc_plus4_nxt_s = pc_plus4_in;
            ifid_valid_nxt_s    = 1'b1;
            fetch_count_nxt_s   = fetch_count_r + 32'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r            <= RESET_PC;
            ifid_instr_r    <= NOP_INSTR;
            ifid_pc_plus4_r <= 32'h0000_0000;
            ifid_valid_r    <= 1'b0;
            misalign_err_r  <= 1'b0;
            fetch_count_r   <= 32'h0000_0000;
        end else begin
            pc_r            <= pc_nxt_s;
            ifid_instr_r    <= ifid_instr_nxt_s;
            ifid_pc_plus4_r <= ifid_pc_plus4_nxt_s;
            ifid_valid_r    <= ifid_valid_nxt_s;
            misalign_err_r  <= misalign_err_nxt_s;
            fetch_count_r   <= fetch_count_nxt_s;
        end
    end

    assign pc_out        = pc_r;
    assign ifid_instr    = ifid_instr_r;
    assign ifid_pc_plus4 = ifid_pc_plus4_r;
    assign ifid_valid    = ifid_valid_r;
    assign misalign_err  = misalign_err_r;
    assign fetch_count   = fetch_count_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: the stimulus process pushes hand-computed
// expectations after each clock edge, and a monitor process pops and checks
// them on the following falling edge.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_in;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_out        (pc_out),
        .pc_plus4_in   (pc_plus4_in),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    // Shared adder and instruction memory models.
    assign pc_plus4_in = pc_out + 32'd4;
    assign imem_rdata  = (pc_out == 32'h0000_0000) ? 32'h2008_0005 : (pc_out ^ 32'hA5A5_0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h exp=%h", name, fld, got, want);
        end
    endtask

    // Monitor: one expectation checked per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pc_out", pc_out, e.pc);
                chk(e.name, "ifid_instr", ifid_instr, e.instr);
                chk(e.name, "ifid_pc_plus4", ifid_pc_plus4, e.pc4);
                chk(e.name, "ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
                chk(e.name, "misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
                chk(e.name, "fetch_count", fetch_count, e.cnt);
            end
        end
    end

    task automatic push(input string name, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic valid, input logic mis, input logic [31:0] cnt);
        exp_t e;
        e.name = name; e.pc = pc; e.instr = instr; e.pc4 = pc4;
        e.valid = valid; e.mis = mis; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs, then queue the expected post-edge state.
    task automatic step(input string name, input logic st, input logic bt, input logic [31:0] bta,
                        input logic je, input logic [31:0] jta,
                        input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic valid, input logic mis, input logic [31:0] cnt);
        stall = st; branch_taken = bt; branch_target = bta; jump_en = je; jump_target = jta;
        @(posedge clk);
        #1;
        push(name, pc, instr, pc4, valid, mis, cnt);
        stall = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        @(negedge clk); #1;
        push("reset_init", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        //    name          st    bt    bta            je    jta            pc             instr          pc4            v     mis   cnt
        step("seq0",        1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h4,         32'h2008_0005, 32'h4,         1'b1, 1'b0, 32'd1);
        step("seq1",        1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8,         32'hA5A5_0004, 32'h8,         1'b1, 1'b0, 32'd2);
        for (int i = 0; i < 3; i++)
            step("stall",   1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h8,         32'hA5A5_0004, 32'h8,         1'b1, 1'b0, 32'd2);
        step("br_stall",    1'b1, 1'b1, 32'h40,        1'b0, 32'h0,         32'h40,        32'h0,         32'h0,         1'b0, 1'b0, 32'd2);
        step("after_br",    1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h44,        32'hA5A5_0040, 32'h44,        1'b1, 1'b0, 32'd3);
        step("jmp_vs_br",   1'b0, 1'b1, 32'h80,        1'b1, 32'h100,       32'h100,       32'h0,         32'h0,         1'b0, 1'b0, 32'd3);
        step("after_jmp",   1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h104,       32'hA5A5_0100, 32'h104,       1'b1, 1'b0, 32'd4);
        step("jmp_misal",   1'b0, 1'b0, 32'h0,         1'b1, 32'h103,       32'h100,       32'h0,         32'h0,         1'b0, 1'b1, 32'd4);
        step("mis_sticky",  1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h104,       32'hA5A5_0100, 32'h104,       1'b1, 1'b1, 32'd5);
        step("br_top",      1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0, 1'b1, 32'd5);
        step("pc_wrap",     1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h5A5A_FFFC, 32'h0,         1'b1, 1'b1, 32'd6);
        step("post_wrap",   1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h4,         32'h2008_0005, 32'h4,         1'b1, 1'b1, 32'd7);
        // Asynchronous reset mid-run, checked before any further rising edge.
        @(negedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        push("reset_async", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        // Jump target wins, so the misaligned branch target is ignored.
        step("jmp_pri_mis", 1'b0, 1'b1, 32'h81,        1'b1, 32'h200,       32'h200,       32'h0,         32'h0,         1'b0, 1'b0, 32'd0);
        step("after_jmp2",  1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h204,       32'hA5A5_0200, 32'h204,       1'b1, 1'b0, 32'd1);
        step("br_misal",    1'b0, 1'b1, 32'h42,        1'b0, 32'h0,         32'h40,        32'h0,         32'h0,         1'b0, 1'b1, 32'd1);
        step("stall_bub",   1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h40,        32'h0,         32'h0,         1'b0, 1'b1, 32'd1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
